// File: rtl/nts_tx_buffer_pkg.sv
// Shared definitions for the engine-side TX packet buffer.
package nts_tx_buffer_pkg;

  // Byte-count width of the final word of a packet.
  localparam int LAST_DATA_VALID_WIDTH = 4;

  // Buffer life cycle of a single packet.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AVAILABLE = 2'd1,
    READ      = 2'd2,
    DRAINED   = 2'd3
  } state_t;

endpackage

// File: rtl/nts_tx_buffer_ram.sv
// Simple dual-port packet store: one write port, one registered read port.
// The read register only updates on a read so the streamed word holds when idle.
module nts_tx_buffer_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; output register clears on reset, holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      rd_data_reg <= '0;
    end else if (i_rd_en) begin
      rd_data_reg <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/nts_tx_buffer.sv
// Engine-side TX buffer: captures one packet from the engine core, advertises
// it to the extractor and streams it out word by word on request.
module nts_tx_buffer #(
  parameter int ADDR_WIDTH            = 8,
  parameter int MAC_DATA_WIDTH        = 64,
  parameter int LAST_DATA_VALID_WIDTH = nts_tx_buffer_pkg::LAST_DATA_VALID_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_areset,
  input  logic                             i_write_en,
  input  logic [MAC_DATA_WIDTH-1:0]        i_write_data,
  input  logic                             i_write_last,
  input  logic [LAST_DATA_VALID_WIDTH-1:0] i_write_last_bytes,
  output logic                             o_write_ready,
  output logic                             o_write_error,
  output logic                             o_packet_available,
  input  logic                             i_packet_read,
  output logic                             o_fifo_empty,
  input  logic                             i_fifo_rd_start,
  output logic                             o_fifo_rd_valid,
  output logic [MAC_DATA_WIDTH-1:0]        o_fifo_rd_data,
  output logic [LAST_DATA_VALID_WIDTH-1:0] o_bytes_last_word
);

  import nts_tx_buffer_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                           state_reg, state_next;
  logic [ADDR_WIDTH-1:0]            wr_ptr_reg, wr_ptr_next;
  logic                             bad_reg, bad_next;
  logic [ADDR_WIDTH:0]              word_count_reg, word_count_next;
  logic [LAST_DATA_VALID_WIDTH-1:0] bytes_reg, bytes_next;
  logic [ADDR_WIDTH-1:0]            rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]              rd_cnt_reg, rd_cnt_next;
  logic                             rd_valid_reg, rd_valid_next;
  logic                             write_error_reg, write_error_next;
  logic                             ram_wr_en;
  logic                             ram_rd_en;

  nts_tx_buffer_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (MAC_DATA_WIDTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .i_wr_en   (ram_wr_en),
    .i_wr_addr (wr_ptr_reg),
    .i_wr_data (i_write_data),
    .i_rd_en   (ram_rd_en),
    .i_rd_addr (rd_ptr_reg),
    .o_rd_data (o_fifo_rd_data)
  );

  // State register and datapath registers; reset returns to an empty IDLE buffer.
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      bad_reg         <= 1'b0;
      word_count_reg  <= '0;
      bytes_reg       <= '0;
      rd_ptr_reg      <= '0;
      rd_cnt_reg      <= '0;
      rd_valid_reg    <= 1'b0;
      write_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      bad_reg         <= bad_next;
      word_count_reg  <= word_count_next;
      bytes_reg       <= bytes_next;
      rd_ptr_reg      <= rd_ptr_next;
      rd_cnt_reg      <= rd_cnt_next;
      rd_valid_reg    <= rd_valid_next;
      write_error_reg <= write_error_next;
    end
  end

  // Next-state logic: packet capture in IDLE, streaming in READ, release anywhere else.
  always_comb begin
    state_next       = state_reg;
    wr_ptr_next      = wr_ptr_reg;
    bad_next         = bad_reg;
    word_count_next  = word_count_reg;
    bytes_next       = bytes_reg;
    rd_ptr_next      = rd_ptr_reg;
    rd_cnt_next      = rd_cnt_reg;
    rd_valid_next    = 1'b0;
    write_error_next = 1'b0;
    ram_wr_en        = 1'b0;
    ram_rd_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_write_en) begin
          if (i_write_last) begin
            if (bad_reg) begin
              // End of an overflowed packet: report it and start over.
              write_error_next = 1'b1;
              wr_ptr_next      = '0;
              bad_next         = 1'b0;
            end else begin
              ram_wr_en       = 1'b1;
              word_count_next = {1'b0, wr_ptr_reg} + CNT_ONE;
              bytes_next      = i_write_last_bytes;
              state_next      = AVAILABLE;
            end
          end else if (!bad_reg) begin
            ram_wr_en = 1'b1;
            // The final slot is filled but more words follow: the packet cannot fit.
            if (wr_ptr_reg == PTR_MAX) begin
              bad_next = 1'b1;
            end else begin
              wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
          end
        end
      end

      AVAILABLE: begin
        if (i_packet_read) begin
          state_next  = IDLE;
          wr_ptr_next = '0;
        end else if (i_fifo_rd_start) begin
          state_next  = READ;
          rd_ptr_next = '0;
          rd_cnt_next = '0;
        end
      end

      READ: begin
        if (i_packet_read) begin
          state_next  = IDLE;
          wr_ptr_next = '0;
        end else begin
          // Issue one read per cycle until every word has been requested.
          if (rd_cnt_reg < word_count_reg) begin
            ram_rd_en     = 1'b1;
            rd_ptr_next   = rd_ptr_reg + PTR_ONE;
            rd_cnt_next   = rd_cnt_reg + CNT_ONE;
            rd_valid_next = 1'b1;
          end
          // Leave READ once the final word is on the output.
          if (rd_valid_reg && (rd_cnt_reg == word_count_reg)) begin
            state_next = DRAINED;
          end
        end
      end

      DRAINED: begin
        if (i_packet_read) begin
          state_next  = IDLE;
          wr_ptr_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The buffer is busy with a packet: any write attempt is refused.
    if (i_write_en && (state_reg != IDLE)) begin
      write_error_next = 1'b1;
    end
  end

  assign o_write_ready      = (state_reg == IDLE);
  assign o_packet_available = (state_reg != IDLE);
  assign o_fifo_empty       = (state_reg == IDLE) || (state_reg == DRAINED);
  assign o_fifo_rd_valid    = rd_valid_reg;
  assign o_write_error      = write_error_reg;
  assign o_bytes_last_word  = bytes_reg;

endmodule

// File: tb/tb_nts_tx_buffer.sv
// Directed self-checking bench for nts_tx_buffer with a word scoreboard.
module tb_nts_tx_buffer;

  logic        i_clk;
  logic        i_areset;
  logic        i_write_en;
  logic [63:0] i_write_data;
  logic        i_write_last;
  logic [3:0]  i_write_last_bytes;
  logic        o_write_ready;
  logic        o_write_error;
  logic        o_packet_available;
  logic        i_packet_read;
  logic        o_fifo_empty;
  logic        i_fifo_rd_start;
  logic        o_fifo_rd_valid;
  logic [63:0] o_fifo_rd_data;
  logic [3:0]  o_bytes_last_word;

  logic [63:0] exp_q [$];
  int          n_cmp;
  int          n_err;

  nts_tx_buffer dut (
    .i_clk              (i_clk),
    .i_areset           (i_areset),
    .i_write_en         (i_write_en),
    .i_write_data       (i_write_data),
    .i_write_last       (i_write_last),
    .i_write_last_bytes (i_write_last_bytes),
    .o_write_ready      (o_write_ready),
    .o_write_error      (o_write_error),
    .o_packet_available (o_packet_available),
    .i_packet_read      (i_packet_read),
    .o_fifo_empty       (o_fifo_empty),
    .i_fifo_rd_start    (i_fifo_rd_start),
    .o_fifo_rd_valid    (o_fifo_rd_valid),
    .o_fifo_rd_data     (o_fifo_rd_data),
    .o_bytes_last_word  (o_bytes_last_word)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write an n-word packet; ok says whether the buffer should accept it.
  // A zero seed selects random data, otherwise word i is seed*(i+1).
  task automatic write_pkt(input int n, input logic [3:0] lb, input logic [63:0] seed, input bit ok);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = (seed == 64'd0) ? {$urandom(), $urandom()} : seed * 64'(i + 1);
      i_write_en         = 1'b1;
      i_write_data       = d;
      i_write_last       = (i == n - 1);
      i_write_last_bytes = lb;
      if (ok) exp_q.push_back(d);
      tick();
    end
    i_write_en   = 1'b0;
    i_write_last = 1'b0;
    check("wr_error_after_last", o_write_error, !ok);
    check("pkt_avail_after_write", o_packet_available, ok);
    check("wr_ready_after_write", o_write_ready, !ok);
    if (ok) check("bytes_last_word", o_bytes_last_word, lb);
  endtask

  // Stream the stored packet and compare against the scoreboard, then release it.
  task automatic stream_pkt(input int wc, input logic [3:0] lb);
    logic [63:0] exp;
    i_fifo_rd_start = 1'b1;
    tick();
    i_fifo_rd_start = 1'b0;
    check("rd_valid_T+1", o_fifo_rd_valid, 1'b0);
    tick();
    for (int k = 0; k < wc; k++) begin
      exp = 64'd0;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      check("rd_valid", o_fifo_rd_valid, 1'b1);
      check("rd_data", o_fifo_rd_data, exp);
      if (k == 0) check("empty_during_read", o_fifo_empty, 1'b0);
      tick();
    end
    check("rd_valid_after_last", o_fifo_rd_valid, 1'b0);
    check("empty_after_last", o_fifo_empty, 1'b1);
    check("avail_when_drained", o_packet_available, 1'b1);
    check("bytes_when_drained", o_bytes_last_word, lb);
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    check("avail_after_release", o_packet_available, 1'b0);
    check("ready_after_release", o_write_ready, 1'b1);
    check("empty_after_release", o_fifo_empty, 1'b1);
  endtask

  initial begin
    n_cmp              = 0;
    n_err              = 0;
    i_areset           = 1'b1;
    i_write_en         = 1'b0;
    i_write_data       = 64'd0;
    i_write_last       = 1'b0;
    i_write_last_bytes = 4'd0;
    i_packet_read      = 1'b0;
    i_fifo_rd_start    = 1'b0;

    // Reset values.
    tick();
    tick();
    i_areset = 1'b0;
    check("rst_write_ready", o_write_ready, 1'b1);
    check("rst_fifo_empty", o_fifo_empty, 1'b1);
    check("rst_bytes", o_bytes_last_word, 4'd0);
    check("rst_rd_data", o_fifo_rd_data, 64'd0);
    check("rst_rd_valid", o_fifo_rd_valid, 1'b0);
    check("rst_avail", o_packet_available, 1'b0);
    check("rst_write_error", o_write_error, 1'b0);
    tick();

    // Three-word packet, five bytes in the last word.
    write_pkt(3, 4'd5, 64'h1111_1111_1111_1111, 1'b1);
    stream_pkt(3, 4'd5);

    // Largest packet: 256 words.
    write_pkt(256, 4'd7, 64'd0, 1'b1);
    stream_pkt(256, 4'd7);

    // Overflowing packet: 257 words is refused as a whole.
    write_pkt(257, 4'd3, 64'd0, 1'b0);
    tick();
    check("overflow_error_one_cycle", o_write_error, 1'b0);
    check("overflow_no_avail", o_packet_available, 1'b0);

    // Buffer usable again after the overflow.
    write_pkt(2, 4'd2, 64'h0102_0304_0506_0708, 1'b1);
    stream_pkt(2, 4'd2);

    // Abort a 10-word stream on its second valid word.
    write_pkt(10, 4'd4, 64'd0, 1'b1);
    i_fifo_rd_start = 1'b1;
    tick();
    i_fifo_rd_start = 1'b0;
    tick();
    check("abort_valid_1", o_fifo_rd_valid, 1'b1);
    check("abort_data_1", o_fifo_rd_data, exp_q.pop_front());
    tick();
    check("abort_valid_2", o_fifo_rd_valid, 1'b1);
    check("abort_data_2", o_fifo_rd_data, exp_q[0]);
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    check("abort_valid_off", o_fifo_rd_valid, 1'b0);
    check("abort_data_hold", o_fifo_rd_data, exp_q.pop_front());
    check("abort_empty", o_fifo_empty, 1'b1);
    check("abort_ready", o_write_ready, 1'b1);
    check("abort_avail", o_packet_available, 1'b0);
    tick();
    check("abort_valid_stays_off", o_fifo_rd_valid, 1'b0);
    exp_q.delete();
    write_pkt(3, 4'd6, 64'd0, 1'b1);
    stream_pkt(3, 4'd6);

    // Write attempt while a packet is held.
    write_pkt(4, 4'd1, 64'd0, 1'b1);
    i_write_en   = 1'b1;
    i_write_data = 64'hDEAD_BEEF_DEAD_BEEF;
    i_write_last = 1'b1;
    tick();
    i_write_en   = 1'b0;
    i_write_last = 1'b0;
    check("busy_write_error", o_write_error, 1'b1);
    check("busy_avail", o_packet_available, 1'b1);
    check("busy_ready", o_write_ready, 1'b0);
    tick();
    check("busy_error_one_cycle", o_write_error, 1'b0);
    stream_pkt(4, 4'd1);

    // Start and release together: release wins.
    write_pkt(2, 4'd8, 64'd0, 1'b1);
    i_fifo_rd_start = 1'b1;
    i_packet_read   = 1'b1;
    tick();
    i_fifo_rd_start = 1'b0;
    i_packet_read   = 1'b0;
    check("both_avail", o_packet_available, 1'b0);
    check("both_ready", o_write_ready, 1'b1);
    check("both_valid", o_fifo_rd_valid, 1'b0);
    tick();
    check("both_valid_later", o_fifo_rd_valid, 1'b0);
    exp_q.delete();

    // Reset in the middle of a stream.
    write_pkt(5, 4'd3, 64'd0, 1'b1);
    i_fifo_rd_start = 1'b1;
    tick();
    i_fifo_rd_start = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", o_fifo_rd_valid, 1'b1);
    i_areset = 1'b1;
    tick();
    i_areset = 1'b0;
    check("mid_rst_write_ready", o_write_ready, 1'b1);
    check("mid_rst_fifo_empty", o_fifo_empty, 1'b1);
    check("mid_rst_bytes", o_bytes_last_word, 4'd0);
    check("mid_rst_rd_data", o_fifo_rd_data, 64'd0);
    check("mid_rst_rd_valid", o_fifo_rd_valid, 1'b0);
    check("mid_rst_avail", o_packet_available, 1'b0);
    check("mid_rst_write_error", o_write_error, 1'b0);
    exp_q.delete();
    write_pkt(1, 4'd8, 64'hCAFE_F00D_1234_5678, 1'b1);
    stream_pkt(1, 4'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
